taillight_pattern_monitor: RTL and testbench
============================================

Name: taillight_pattern_monitor

Overview:
Receive-side companion to the T-Bird tail-light controller. It samples the six lamp lines that the controller drives and decodes them back into turn/hazard events. It also checks every lamp-pattern change against the controller's legal state graph and flags illegal codes, illegal transitions and stuck lamps. It sits on a separate TinyTapeout slot or a bench board, with the lamp lines wired into io_in[7:2] and on the same clock as the controller.

Parameters:
HOLD_MAX, 1024, maximum number of clocks a non-IDLE pattern may stay unchanged before timeout (controller step period is 781 clocks at 6250 Hz / 8 Hz).

Ports:
clk (io_in[0])  input  1  system clock, rising edge
reset (io_in[1])  input  1  synchronous, active-high reset
lights (io_in[7:2])  input  6  lamp lines; lights[5:3] = left lamps (L3..L1 outer-to-inner), lights[2:0] = right lamps
left_done (io_out[0])  output  1  one-clock pulse: complete L1,L2,L3,IDLE sequence seen
right_done (io_out[1])  output  1  one-clock pulse: complete R1,R2,R3,IDLE sequence seen
haz_flash (io_out[2])  output  1  one-clock pulse on each legal entry into LR3
error (io_out[3])  output  1  sticky; any violation
illegal_code (io_out[4])  output  1  sticky; sampled pattern is not one of the 8 codes
mode (io_out[6:5])  output  2  current decoded mode: 00 idle, 01 left, 10 right, 11 hazard
timeout (io_out[7])  output  1  sticky; non-IDLE pattern held longer than HOLD_MAX

Behaviour:
- Legal codes: IDLE 000000, L1 001000, L2 011000, L3 111000, R1 000100, R2 000110, R3 000111, LR3 111111.
- Input path: two-flop synchronizer s1->s2, plus prev register holding the last s2 value. A change event occurs when s2 != prev.
- Latency: if lights change before rising edge k, the registered outputs reflect the change after edge k+2.
- Tracked state trk (one of the 8 codes) and flag seq_ok (1 bit).
- On a change event to code N, the transition from trk is legal if:
  - IDLE -> L1, R1 or LR3
  - L1 -> L2 or LR3; L2 -> L3 or LR3; L3 -> IDLE or LR3
  - R1 -> R2 or LR3; R2 -> R3 or LR3; R3 -> IDLE or LR3
  - LR3 -> IDLE
- Legal transition:
  - trk <= N.
  - IDLE->L1 or IDLE->R1 sets seq_ok.
  - Entry into LR3 clears seq_ok and pulses haz_flash.
  - L3->IDLE with seq_ok=1 pulses left_done; R3->IDLE with seq_ok=1 pulses right_done.
- Illegal transition (N is legal code but edge not in graph):
  - error <= 1.
  - trk <= N (resynchronise), seq_ok <= 0, no pulse.
- N not a legal code:
  - illegal_code <= 1, error <= 1.
  - trk <= IDLE, seq_ok <= 0.
- mode is registered from trk: L1..L3 -> 01, R1..R3 -> 10, LR3 -> 11, IDLE -> 00.
- Hold counter:
  - Width $clog2(HOLD_MAX+1), saturating.
  - Cleared on every change event and whenever trk = IDLE; otherwise increments each clock.
  - When the count reaches HOLD_MAX: timeout <= 1, error <= 1. trk is unchanged.
- IDLE may persist indefinitely without error.
- Sticky flags clear only on reset.
- Reset (any cycle, including mid-sequence):
  - s1, s2, prev <= 000000; trk <= IDLE; seq_ok <= 0; counter <= 0.
  - All io_out bits <= 0.
  - The first post-reset sample equal to 000000 is not a change event.
- Simultaneous change event and counter hit: the change event wins; counter clears and no timeout.
- Pulses are exactly one clock wide, even if a pattern repeats.

Test Plan:
- Reset, then drive 001000, 011000, 111000, 000000 at 781-clock spacing -> mode=01 from 3 clocks after the first step; left_done high for exactly one clock 3 clocks after 000000; error=0.
- Drive 000100, 000110, 000111, 000000 -> mode=10 during the sequence; one right_done pulse; no left_done.
- Drive 001000 then 111111 then 000000 -> haz_flash pulse, mode=11 then 00, no left_done (seq_ok cleared); error=0.
- Drive 001000 directly to 111000 -> error=1, illegal_code=0, mode stays 01, no left_done at the following 000000.
- Drive 101000 -> illegal_code=1, error=1, mode=00; both flags remain set until reset.
- Hold 011000 for 1100 clocks -> timeout=1 and error=1 exactly HOLD_MAX=1024 clocks after the synchronized change; assert reset mid-hold -> all io_out=0 on the next clock.

Source files
------------

// File: rtl/taillight_pattern_monitor.sv
// Receive-side checker for the T-Bird tail-light controller: decodes the six lamp lines into
// turn/hazard events and flags illegal codes, illegal transitions and stuck lamp patterns.
module taillight_pattern_monitor #(
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] lights,
  output logic       left_done,
  output logic       right_done,
  output logic       haz_flash,
  output logic       error,
  output logic       illegal_code,
  output logic [1:0] mode,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HoldMax = CW'(HOLD_MAX);

  typedef enum logic [2:0] {StIdle, StL1, StL2, StL3, StR1, StR2, StR3, StLr3} trk_e;

  logic [5:0]    r_s1, r_s2, r_prev;
  trk_e          r_trk, w_trk_d;
  logic          r_seq_ok, w_seq_ok_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_left_done, r_right_done, r_haz_flash, r_error, r_illegal, r_timeout;
  logic          w_left_d, w_right_d, w_haz_d, w_error_d, w_illegal_d, w_timeout_d;
  logic [1:0]    r_mode, w_mode_d;
  logic          w_chg, w_code_ok, w_edge_ok;
  trk_e          w_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_prev       <= '0;
      r_trk        <= StIdle;
      r_seq_ok     <= 1'b0;
      r_cnt        <= '0;
      r_left_done  <= 1'b0;
      r_right_done <= 1'b0;
      r_haz_flash  <= 1'b0;
      r_error      <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      r_mode       <= 2'b00;
    end else begin
      r_s1         <= lights;
      r_s2         <= r_s1;
      r_prev       <= r_s2;
      r_trk        <= w_trk_d;
      r_seq_ok     <= w_seq_ok_d;
      r_cnt        <= w_cnt_d;
      r_left_done  <= w_left_d;
      r_right_done <= w_right_d;
      r_haz_flash  <= w_haz_d;
      r_error      <= w_error_d;
      r_illegal    <= w_illegal_d;
      r_timeout    <= w_timeout_d;
      r_mode       <= w_mode_d;
    end
  end

  always_comb begin
    w_code_ok = 1'b1;
    w_code    = StIdle;
    case (r_s2)
      6'b000000: w_code = StIdle;
      6'b001000: w_code = StL1;
      6'b011000: w_code = StL2;
      6'b111000: w_code = StL3;
      6'b000100: w_code = StR1;
      6'b000110: w_code = StR2;
      6'b000111: w_code = StR3;
      6'b111111: w_code = StLr3;
      default:   w_code_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_edge_ok = 1'b0;
    case (r_trk)
      StIdle:  w_edge_ok = (w_code == StL1) || (w_code == StR1) || (w_code == StLr3);
      StL1:    w_edge_ok = (w_code == StL2) || (w_code == StLr3);
      StL2:    w_edge_ok = (w_code == StL3) || (w_code == StLr3);
      StL3:    w_edge_ok = (w_code == StIdle) || (w_code == StLr3);
      StR1:    w_edge_ok = (w_code == StR2) || (w_code == StLr3);
      StR2:    w_edge_ok = (w_code == StR3) || (w_code == StLr3);
      StR3:    w_edge_ok = (w_code == StIdle) || (w_code == StLr3);
      StLr3:   w_edge_ok = (w_code == StIdle);
      default: w_edge_ok = 1'b0;
    endcase
  end

  assign w_chg = (r_s2 != r_prev);

  always_comb begin
    w_trk_d     = r_trk;
    w_seq_ok_d  = r_seq_ok;
    w_left_d    = 1'b0;
    w_right_d   = 1'b0;
    w_haz_d     = 1'b0;
    w_error_d   = r_error;
    w_illegal_d = r_illegal;
    w_timeout_d = r_timeout;
    w_cnt_d     = r_cnt;
    w_mode_d    = 2'b00;

    if (w_chg) begin
      if (!w_code_ok) begin
        w_illegal_d = 1'b1;
        w_error_d   = 1'b1;
        w_trk_d     = StIdle;
        w_seq_ok_d  = 1'b0;
      end else if (w_edge_ok) begin
        w_trk_d = w_code;
        if ((r_trk == StIdle) && ((w_code == StL1) || (w_code == StR1))) w_seq_ok_d = 1'b1;
        if (w_code == StLr3) begin
          w_seq_ok_d = 1'b0;
          w_haz_d    = 1'b1;
        end
        if ((r_trk == StL3) && (w_code == StIdle) && r_seq_ok) w_left_d = 1'b1;
        if ((r_trk == StR3) && (w_code == StIdle) && r_seq_ok) w_right_d = 1'b1;
      end else begin
        // Resynchronise to the observed code so one glitch yields one error, not a cascade
        w_error_d  = 1'b1;
        w_trk_d    = w_code;
        w_seq_ok_d = 1'b0;
      end
    end

    // A change event in the same cycle as the counter hit wins: the count clears instead
    if (w_chg || (r_trk == StIdle)) begin
      w_cnt_d = '0;
    end else begin
      if (r_cnt != HoldMax) w_cnt_d = r_cnt + 1'b1;
      if (w_cnt_d == HoldMax) begin
        w_timeout_d = 1'b1;
        w_error_d   = 1'b1;
      end
    end

    case (w_trk_d)
      StL1, StL2, StL3: w_mode_d = 2'b01;
      StR1, StR2, StR3: w_mode_d = 2'b10;
      StLr3:            w_mode_d = 2'b11;
      default:          w_mode_d = 2'b00;
    endcase
  end

  assign left_done    = r_left_done;
  assign right_done   = r_right_done;
  assign haz_flash    = r_haz_flash;
  assign error        = r_error;
  assign illegal_code = r_illegal;
  assign mode         = r_mode;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_taillight_pattern_monitor.sv
// Directed bench: each stimulus step pushes the io_out value it should produce, tagged with the
// cycle it is due; a negedge monitor pops and compares.
module tb_taillight_pattern_monitor;

  localparam int STEP = 781;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] lights;
  logic       left_done, right_done, haz_flash, error, illegal_code, timeout;
  logic [1:0] mode;
  logic [7:0] w_out;

  taillight_pattern_monitor #(.HOLD_MAX(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .lights       (lights),
    .left_done    (left_done),
    .right_done   (right_done),
    .haz_flash    (haz_flash),
    .error        (error),
    .illegal_code (illegal_code),
    .mode         (mode),
    .timeout      (timeout)
  );

  // {timeout, mode, illegal_code, error, haz_flash, right_done, left_done}
  assign w_out = {timeout, mode, illegal_code, error, haz_flash, right_done, left_done};

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t it;
      it = q.pop_front();
      n_chk++;
      assert (w_out === it.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: io_out=%h expected %h (cycle %0d)", it.tag, w_out, it.exp, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_at(input int d, input string tag, input logic [7:0] v);
    exp_t it;
    int   i;
    it.due = cyc + d;
    it.tag = tag;
    it.exp = v;
    i = 0;
    while (i < q.size() && q[i].due <= it.due) i++;
    q.insert(i, it);
  endtask

  initial begin
    reset  = 1'b1;
    lights = 6'b000000;
    tick(1);
    exp_at(1, "reset_hold", 8'h00);
    tick(2);
    reset = 1'b0;
    exp_at(2, "reset_idle", 8'h00);
    tick(4);

    // Full left sequence
    lights = 6'b001000;
    exp_at(2, "l1_latency", 8'h00);
    exp_at(3, "l1_mode", 8'h20);
    tick(STEP);
    lights = 6'b011000;
    exp_at(3, "l2_mode", 8'h20);
    tick(STEP);
    lights = 6'b111000;
    exp_at(3, "l3_mode", 8'h20);
    tick(STEP);
    lights = 6'b000000;
    exp_at(2, "l_idle_pre", 8'h20);
    exp_at(3, "left_done", 8'h01);
    exp_at(4, "left_done_end", 8'h00);
    tick(20);

    // Full right sequence
    lights = 6'b000100;
    exp_at(3, "r1_mode", 8'h40);
    tick(STEP);
    lights = 6'b000110;
    exp_at(3, "r2_mode", 8'h40);
    tick(STEP);
    lights = 6'b000111;
    exp_at(3, "r3_mode", 8'h40);
    tick(STEP);
    lights = 6'b000000;
    exp_at(3, "right_done", 8'h02);
    exp_at(4, "right_done_end", 8'h00);
    tick(20);

    // Hazard interrupts a left sequence
    lights = 6'b001000;
    exp_at(3, "haz_l1", 8'h20);
    tick(STEP);
    lights = 6'b111111;
    exp_at(3, "haz_flash", 8'h64);
    exp_at(4, "haz_mode", 8'h60);
    tick(STEP);
    lights = 6'b000000;
    exp_at(3, "haz_idle", 8'h00);
    exp_at(4, "haz_no_done", 8'h00);
    tick(20);

    // Skipped step L1 -> L3
    lights = 6'b001000;
    exp_at(3, "skip_l1", 8'h20);
    tick(STEP);
    lights = 6'b111000;
    exp_at(3, "skip_err", 8'h28);
    tick(STEP);
    lights = 6'b000000;
    exp_at(3, "skip_no_done", 8'h08);
    exp_at(4, "skip_no_done2", 8'h08);
    tick(20);

    // Undefined lamp code
    lights = 6'b101000;
    exp_at(3, "illegal", 8'h18);
    tick(STEP);
    lights = 6'b000000;
    exp_at(3, "illegal_sticky", 8'h18);
    tick(20);

    reset = 1'b1;
    exp_at(1, "reset_clears", 8'h00);
    tick(2);
    reset = 1'b0;
    tick(4);

    // Stuck lamp pattern
    lights = 6'b001000;
    exp_at(3, "hold_l1", 8'h20);
    tick(STEP);
    lights = 6'b011000;
    exp_at(3, "hold_l2", 8'h20);
    exp_at(1026, "hold_pre_timeout", 8'h20);
    exp_at(1027, "timeout", 8'hA8);
    exp_at(1049, "timeout_sticky", 8'hA8);
    tick(1050);
    reset  = 1'b1;
    lights = 6'b000000;
    exp_at(1, "reset_mid_hold", 8'h00);
    tick(3);
    reset = 1'b0;
    tick(8);

    if (q.size() > 0) begin
      $display("FAIL scoreboard: %0d checks never reached, expected 0", q.size());
      n_chk  += q.size();
      n_fail += q.size();
      q.delete();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
